// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative EX-stage multiply/divide unit (MULT, MULTU, DIV, DIVU)
//
// Purpose : computes 2*DATA_W-bit products and DATA_W-bit quotient/remainder into
//           HI/LO. Multiply uses a radix-2 shift-add, divide a restoring shift-subtract,
//           DATA_W steps in CALC, then a sign fix-up and result register in FIX.
// Option  : MULDIV_FAST_MULT_EN - when defined, MULT/MULTU skip CALC and FIX uses a
//           single-cycle combinational multiplier; divides are unaffected.
// Ports   : Clk, Reset (async, active-low)
//           Start, Op[1:0] (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), Op_A, Op_B, Flush
//           Busy (CALC/FIX), Done (one-cycle pulse), HI_Out, LO_Out, HI_WE, LO_WE,
//           Div_By_Zero (with Done, divide by zero)
module ex_muldiv_unit #(
   parameter int DATA_W = 32
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [1:0]        Op,
   input  logic [DATA_W-1:0] Op_A,
   input  logic [DATA_W-1:0] Op_B,
   input  logic              Flush,
   output logic              Busy,
   output logic              Done,
   output logic [DATA_W-1:0] HI_Out,
   output logic [DATA_W-1:0] LO_Out,
   output logic              HI_WE,
   output logic              LO_WE,
   output logic              Div_By_Zero
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t state, state_nxt;

   logic [1:0]          op_q;
   logic                sign_a, sign_b;
   logic [DATA_W-1:0]   a_raw;      // dividend as issued, returned in HI on divide by zero
   logic [DATA_W-1:0]   b_mag;      // |multiplicand| or |divisor|
   logic [2*DATA_W-1:0] acc;        // {hi, lo}: product accumulator or {remainder, quotient}
   logic [CNT_W-1:0]    cnt;
   logic                dz_q;

   logic                is_div, is_signed;
   logic                in_signed, sa_in, sb_in;
   logic [DATA_W-1:0]   a_mag_in, b_mag_in;
   logic                launch;
   state_t              start_state;

   logic [DATA_W:0]     mul_sum;
   logic [2*DATA_W-1:0] mul_next;
   logic [DATA_W:0]     rem_sh, rem_diff;
   logic                rem_ge;
   logic [2*DATA_W-1:0] div_next;

   logic [2*DATA_W-1:0] prod_src, prod_fix;
   logic [DATA_W-1:0]   quo_fix, rem_fix;
   logic                div_zero;
   logic [DATA_W-1:0]   hi_res, lo_res;

   assign is_div    = op_q[1];
   assign is_signed = ~op_q[0];

   // Operand conditioning at launch: signed ops work on magnitudes.
   assign in_signed = ~Op[0];
   assign sa_in     = in_signed & Op_A[DATA_W-1];
   assign sb_in     = in_signed & Op_B[DATA_W-1];
   assign a_mag_in  = sa_in ? -Op_A : Op_A;
   assign b_mag_in  = sb_in ? -Op_B : Op_B;

   assign launch = Start && !Flush && ((state == S_IDLE) || (state == S_DONE));

`ifdef MULDIV_FAST_MULT_EN
   assign start_state = Op[1] ? S_CALC : S_FIX;
`else
   assign start_state = S_CALC;
`endif

   // Shift-add step: add multiplicand into the upper half when the current
   // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
   // The extra sum bit keeps the carry out of the upper half.
   always_comb begin
      mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_mag} : '0);
      mul_next = {mul_sum, acc[DATA_W-1:1]};
   end

   // Restoring divide step: shift next dividend bit into the partial remainder,
   // trial-subtract the divisor, keep the difference only if it did not borrow.
   always_comb begin
      rem_sh   = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
      rem_diff = rem_sh - {1'b0, b_mag};
      rem_ge   = ~rem_diff[DATA_W];
      div_next = {(rem_ge ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0]),
                  acc[DATA_W-2:0], rem_ge};
   end

`ifdef MULDIV_FAST_MULT_EN
   assign prod_src = is_div ? acc
                            : ({{DATA_W{1'b0}}, b_mag} * {{DATA_W{1'b0}}, acc[DATA_W-1:0]});
`else
   assign prod_src = acc;
`endif

   // Sign fix-up and result selection used in FIX.
   always_comb begin
      prod_fix = (is_signed && (sign_a ^ sign_b)) ? -prod_src : prod_src;
      quo_fix  = (is_signed && (sign_a ^ sign_b)) ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
      rem_fix  = (is_signed && sign_a) ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
      div_zero = is_div && (b_mag == '0);
      hi_res   = prod_fix[2*DATA_W-1:DATA_W];
      lo_res   = prod_fix[DATA_W-1:0];
      if (is_div) begin
         if (div_zero) begin
            hi_res = a_raw;
            lo_res = '1;
         end else begin
            hi_res = rem_fix;
            lo_res = quo_fix;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_DONE: state_nxt = Start ? start_state : S_IDLE;
         S_CALC:         if (cnt == CNT_LAST) state_nxt = S_FIX;
         S_FIX:          state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
      // Flush dominates everything, including a same-edge Start.
      if (Flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         op_q   <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         a_raw  <= '0;
         b_mag  <= '0;
         acc    <= '0;
         cnt    <= '0;
         dz_q   <= 1'b0;
         HI_Out <= '0;
         LO_Out <= '0;
      end else begin
         unique case (state)
            S_IDLE, S_DONE: begin
               if (launch) begin
                  op_q   <= Op;
                  sign_a <= sa_in;
                  sign_b <= sb_in;
                  a_raw  <= Op_A;
                  b_mag  <= b_mag_in;
                  acc    <= {{DATA_W{1'b0}}, a_mag_in};
                  cnt    <= '0;
               end
            end
            S_CALC: begin
               if (!Flush) begin
                  acc <= is_div ? div_next : mul_next;
                  cnt <= cnt + 1'b1;
               end
            end
            S_FIX: begin
               if (!Flush) begin
                  HI_Out <= hi_res;
                  LO_Out <= lo_res;
                  dz_q   <= div_zero;
               end
            end
            default: ;
         endcase
      end
   end

   assign Busy        = (state == S_CALC) || (state == S_FIX);
   assign Done        = (state == S_DONE);
   assign HI_WE       = Done;
   assign LO_WE       = Done;
   assign Div_By_Zero = Done & dz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] op_a, op_b;
   logic        flush;
   logic        busy, done, hi_we, lo_we, div_by_zero;
   logic [31:0] hi_out, lo_out;

   int total = 0;
   int bad   = 0;

`ifdef MULDIV_FAST_MULT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   ex_muldiv_unit #(.DATA_W(32)) dut (
      .Clk(clk), .Reset(rst_n), .Start(start), .Op(op), .Op_A(op_a), .Op_B(op_b),
      .Flush(flush), .Busy(busy), .Done(done), .HI_Out(hi_out), .LO_Out(lo_out),
      .HI_WE(hi_we), .LO_WE(lo_we), .Div_By_Zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Launch one op, optionally pulse a Start while busy (sampled on edge k+mid),
   // then wait for Done and check latency, busy length, results and pulse width.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int mid);
      int n, nbusy, lat;
      logic seen;
      lat = (FAST && !o[1]) ? 1 : 33;
      @(negedge clk);
      start = 1'b1; op = o; op_a = a; op_b = b;
      @(negedge clk);
      start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h0;
      n = 0; nbusy = 0; seen = 1'b0;
      while (n < 80) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) nbusy++;
         if (mid > 0 && n == mid - 1) begin
            start = 1'b1; op = 2'b01; op_a = 32'd9; op_b = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
      check_eq({tag, "_latency"}, 64'(n), 64'(lat));
      check_eq({tag, "_busy_cycles"}, 64'(nbusy), 64'(lat));
      check_eq({tag, "_hilo"}, {hi_out, lo_out}, {ehi, elo});
      check_eq({tag, "_we_dz"}, {61'd0, hi_we, lo_we, div_by_zero}, {61'd0, 1'b1, 1'b1, edz});
      @(negedge clk);
      check_eq({tag, "_done_one_cycle"}, {62'd0, done, hi_we}, 64'd0);
   endtask

   initial begin
      int ndone;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_outputs",
               {busy, done, hi_we, lo_we, div_by_zero, hi_out, lo_out[26:0]},
               64'd0);
      rst_n = 1'b1;

      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
      run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 0);
      run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
      run_op("divu_z",    2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 0);
      run_op("div_z_neg", 2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0);
      run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
      // Start pulsed at edge k+5 while busy must not disturb DIVU 100/7.
      run_op("divu_mid",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 5);

      // Flush at edge k+10 of DIVU 9/3, with an ignored Start at edge k+5.
      @(negedge clk);
      start = 1'b1; op = 2'b11; op_a = 32'd9; op_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 11; n++) begin
         start = (n == 4);
         flush = (n == 9);
         if (n == 9) check_eq("flush_busy_before", 64'(busy), 64'd1);
         @(negedge clk);
      end
      start = 1'b0; flush = 1'b0;
      check_eq("flush_busy_after", 64'(busy), 64'd0);
      ndone = 0;
      for (int n = 0; n < 40; n++) begin
         if (done || hi_we || lo_we) ndone++;
         @(negedge clk);
      end
      check_eq("flush_no_done", 64'(ndone), 64'd0);
      check_eq("flush_hilo_kept", {hi_out, lo_out}, {32'd2, 32'd14});

      // Async reset at edge k+20 of a MULT.
      @(negedge clk);
      start = 1'b1; op = 2'b00; op_a = 32'd7; op_b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midreset_outputs",
               {busy, done, hi_we, lo_we, div_by_zero, hi_out, lo_out[26:0]},
               64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("multu_after_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
